// File: rtl/elastic_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_pkg
// Description : Shared types and constants for the elastic pipeline register
//               used in the im2col datapath.
//               - elastic_state_e : occupancy state of the two-entry stage
//               - ELASTIC_DEPTH   : number of storage entries (main + skid)
// Revision    : 1.0 - initial release
// ============================================================================
package elastic_pipe_pkg;

    // Occupancy of the stage: no entries, main only, or main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } elastic_state_e;

    localparam int ELASTIC_DEPTH = 2;

endpackage : elastic_pipe_pkg
`default_nettype wire

// File: rtl/elastic_pipe_entry.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_entry
// Description : Single WIDTH-bit storage entry of the elastic pipeline
//               register. Holds its value unless i_load is asserted.
// Ports       : clk_i  - clock, rising edge
//               rst_i  - asynchronous active-high reset (clears to 0)
//               i_load - load enable
//               i_data - data to load
//               o_data - stored data
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule : elastic_pipe_entry
`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_reg
// Description : Elastic (skid-buffered) pipeline register with valid/ready
//               handshakes on both sides. A main entry drives the output; a
//               skid entry catches the one transfer that may arrive while the
//               consumer stalls, so in_ready_o can come straight from a flop
//               and still sustain one transfer per cycle.
// Config      : `define ELASTIC_PIPE_FLUSH_EN adds the synchronous flush_i
//               input (empties the stage, data registers keep their values).
// Ports       : clk_i       - clock, rising edge
//               rst_i       - asynchronous active-high reset
//               flush_i     - synchronous flush (ELASTIC_PIPE_FLUSH_EN only)
//               in_data_i   - upstream data
//               in_valid_i  - upstream data valid
//               in_ready_o  - stage can accept (registered)
//               out_data_o  - downstream data (main entry)
//               out_valid_o - main entry valid
//               out_ready_i - downstream accepts
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe_reg
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef ELASTIC_PIPE_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    elastic_state_e   r_state;
    elastic_state_e   w_state_next;
    logic             r_in_ready;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_load;
    logic             w_skid_load;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_in_fire  = in_valid_i & r_in_ready;
    assign w_out_fire = out_valid_o & out_ready_i;

    // Next-state and entry load decode
    always_comb begin
        w_state_next     = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_main_load  = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load = 1'b1;
                end else if (w_in_fire) begin
                    // Consumer stalled: park the new word in the skid entry.
                    w_skid_load  = 1'b1;
                    w_state_next = FULL;
                end else if (w_out_fire) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready_o is low here, so only the drain side can move.
                if (w_out_fire) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_next     = BUSY;
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
`ifdef ELASTIC_PIPE_FLUSH_EN
        // Flush overrides everything; the word accepted this cycle is dropped.
        if (flush_i) begin
            w_state_next = EMPTY;
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
        end
`endif
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : in_data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            // Look-ahead on next state keeps in_ready_o purely registered.
            r_in_ready <= (w_state_next != FULL);
        end
    end

    elastic_pipe_entry #(
        .WIDTH (WIDTH)
    ) u_main (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_main_load),
        .i_data (w_main_d),
        .o_data (w_main_q)
    );

    elastic_pipe_entry #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_skid_load),
        .i_data (in_data_i),
        .o_data (w_skid_q)
    );

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state != EMPTY);
    assign out_data_o  = w_main_q;

endmodule : elastic_pipe_reg
`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_pipe_reg
// Description : Self-checking testbench for elastic_pipe_reg. Accepted input
//               words are pushed into a scoreboard queue and popped/compared
//               whenever the DUT delivers an output word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe_reg;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    logic [WIDTH-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    elastic_pipe_reg #(
        .WIDTH (WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef ELASTIC_PIPE_FLUSH_EN
        .flush_i     (flush),
`endif
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are driven 1 time unit after the rising edge; outputs are
    // sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: valid=%b data=%h ready=%b, required 0/00/0", out_valid, out_data, in_ready);
        end
        next_cycle();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_edge_ready: ready=%b, required 0", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: ready=%b, required 0 before first edge", in_ready);
        end
        next_cycle();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_edge: ready=%b valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_streaming();
        int         n_in  = 0;
        int         n_out = 0;
        logic [7:0] exp;
        exp_q.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 17; cyc++) begin
            in_valid = (cyc < 16);
            in_data  = 8'(cyc + 1);
            @(negedge clk);
            if (cyc < 16) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ready cyc%0d: ready=%b, required 1", cyc, in_ready);
                end
            end
            if (cyc > 0) begin
                // Word accepted in cycle N must be on the output in cycle N+1.
                exp = 8'(cyc);
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== exp) begin
                    n_fail++;
                    $display("FAIL stream_latency cyc%0d: valid=%b data=%h, required 1/%h", cyc, out_valid, out_data, exp);
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_sb: got %h, required nothing (queue empty)", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        n_fail++;
                        $display("FAIL stream_sb: got %h, required %h", out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                n_in++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_in != 16 || n_out != 16) begin
            n_fail++;
            $display("FAIL stream_count: in=%0d out=%0d, required 16/16", n_in, n_out);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_empty: valid=%b, required 0", out_valid);
        end
        next_cycle();
    endtask

    // Fill main with A1 and skid with A2 while the consumer stalls.
    task automatic fill_full(input logic [7:0] a, input logic [7:0] b);
        exp_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_first_ready: ready=%b, required 1", in_ready);
        end
        if (in_ready) exp_q.push_back(in_data);
        next_cycle();
        in_data = b;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== a) begin
            n_fail++;
            $display("FAIL fill_second: ready=%b valid=%b data=%h, required 1/1/%h", in_ready, out_valid, out_data, a);
        end
        if (in_ready) exp_q.push_back(in_data);
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_stall_skid();
        logic [7:0] exp;
        fill_full(8'hA1, 8'hA2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
                n_fail++;
                $display("FAIL skid_hold%0d: ready=%b valid=%b data=%h, required 0/1/a1", i, in_ready, out_valid, out_data);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                n_fail++;
                $display("FAIL skid_drain%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, exp);
            end
            n_checks++;
            if (in_ready !== (i == 1)) begin
                n_fail++;
                $display("FAIL skid_ready%0d: ready=%b, required %b", i, in_ready, (i == 1));
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_empty: valid=%b ready=%b, required 0/1", out_valid, in_ready);
        end
        next_cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5C;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_accept: ready=%b valid=%b, required 1/0", in_ready, out_valid);
        end
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5C) begin
            n_fail++;
            $display("FAIL drain_out: valid=%b data=%h, required 1/5c", out_valid, out_data);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%b, required 0", out_valid);
        end
        next_cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_random_backpressure();
        int         n_in  = 0;
        int         n_out = 0;
        int         cyc   = 0;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = '0;
        logic [7:0] exp;
        exp_q.delete();
        while ((n_out < 1000) && (cyc < 20000)) begin
            in_valid  = (n_in < 1000) && ($urandom_range(1, 0) == 1);
            in_data   = 8'($urandom);
            out_ready = (n_in >= 1000) || ($urandom_range(1, 0) == 1);
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL rand_stable cyc%0d: valid=%b data=%h, required 1/%h", cyc, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_sb cyc%0d: got %h, required nothing (duplicate)", cyc, out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        n_fail++;
                        $display("FAIL rand_sb cyc%0d: got %h, required %h", cyc, out_data, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            cyc++;
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_out != 1000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: out=%0d left=%0d, required 1000/0", n_out, exp_q.size());
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_empty: valid=%b, required 0", out_valid);
        end
        next_cycle();
    endtask

`ifdef ELASTIC_PIPE_FLUSH_EN
    task automatic test_flush();
        fill_full(8'h11, 8'h22);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: valid=%b ready=%b, required 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak%0d: valid=%b data=%h, required no output", i, out_valid, out_data);
            end
        end
        next_cycle();
        out_ready = 1'b0;
        exp_q.delete();
    endtask
`endif

    task automatic test_reset_midstream();
        fill_full(8'hC3, 8'hC4);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL mid_full: ready=%b valid=%b data=%h, required 0/1/c3", in_ready, out_valid, out_data);
        end
        next_cycle();
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b data=%h ready=%b, required 0/00/0", out_valid, out_data, in_ready);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release_ready: ready=%b, required 0", in_ready);
        end
        next_cycle();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_after_edge: ready=%b valid=%b data=%h, required 1/0/00", in_ready, out_valid, out_data);
        end
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_drain();
        test_random_backpressure();
`ifdef ELASTIC_PIPE_FLUSH_EN
        test_flush();
`endif
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_elastic_pipe_reg
`default_nettype wire
